// File: rtl/sum_frame_pkg.sv
// Shared definitions for the operand/sum frame receiver: FSM states, slot codes, sync word.
package sum_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNCED = 2'd1,
    HAVE_A = 2'd2,
    HAVE_B = 2'd3
  } state_t;

  localparam logic [1:0] SLOT_SYNC = 2'd0;
  localparam logic [1:0] SLOT_A    = 2'd1;
  localparam logic [1:0] SLOT_B    = 2'd2;
  localparam logic [1:0] SLOT_SUM  = 2'd3;

  localparam int SYNC_WORD = 0;

endpackage

// File: rtl/sum_frame_check.sv
// Combinational frame checks: received sum vs zero-extended A+B, and upper-half-zero test for operand words.
module sum_frame_check #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2*DATA_W-1:0] word,
  output logic                upper_nz,
  output logic                sum_bad
);

  logic [DATA_W:0] full;

  assign full     = {1'b0, a} + {1'b0, b};
  assign upper_nz = |word[2*DATA_W-1:DATA_W];
  // Any bit above the DATA_W+1-bit result must be zero for a matching sum.
  assign sum_bad  = word != {{(DATA_W-1){1'b0}}, full};

endmodule

// File: rtl/sum_frame_receiver.sv
// Receive side of the operand/sum frame link: rebuilds A, B and sum, flags sequence and sum errors.
// Optional saturating error counter enabled by defining SUM_FRAME_RX_ERRCNT_EN.
module sum_frame_receiver
  import sum_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                valid_in,
  input  logic [1:0]          slot_in,
  input  logic [2*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]   a_out,
  output logic [DATA_W-1:0]   b_out,
  output logic [2*DATA_W-1:0] sum_out,
  output logic                frame_valid,
  output logic                sum_err,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   sh_a, sh_b, sh_a_nxt, sh_b_nxt;
  logic                accept, ferr, is_sync, upper_nz, sum_bad;

  sum_frame_check #(.DATA_W(DATA_W)) u_check (
    .a        (sh_a),
    .b        (sh_b),
    .word     (data_in),
    .upper_nz (upper_nz),
    .sum_bad  (sum_bad)
  );

  assign is_sync = (slot_in == SLOT_SYNC) && (data_in == (2*DATA_W)'(SYNC_WORD));

  always_comb begin
    state_nxt = state;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    accept    = 1'b0;
    ferr      = 1'b0;
    if (valid_in) begin
      case (state)
        IDLE: if (is_sync) state_nxt = SYNCED;
        SYNCED: begin
          if (is_sync) state_nxt = SYNCED;
          else if (slot_in == SLOT_A && !upper_nz) begin
            sh_a_nxt  = data_in[DATA_W-1:0];
            state_nxt = HAVE_A;
          end else ferr = 1'b1;
        end
        HAVE_A: begin
          if (slot_in == SLOT_B && !upper_nz) begin
            sh_b_nxt  = data_in[DATA_W-1:0];
            state_nxt = HAVE_B;
          end else ferr = 1'b1;
        end
        HAVE_B: begin
          if (slot_in == SLOT_SUM) begin
            accept    = 1'b1;
            state_nxt = IDLE;
          end else ferr = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
      // A violating word that is itself a clean sync starts the next frame.
      if (ferr) begin
        sh_a_nxt  = '0;
        sh_b_nxt  = '0;
        state_nxt = is_sync ? SYNCED : IDLE;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      sh_a        <= '0;
      sh_b        <= '0;
      a_out       <= '0;
      b_out       <= '0;
      sum_out     <= '0;
      frame_valid <= 1'b0;
      sum_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sh_a        <= sh_a_nxt;
      sh_b        <= sh_b_nxt;
      frame_valid <= accept;
      sum_err     <= accept & sum_bad;
      frame_err   <= ferr;
      if (accept) begin
        a_out   <= sh_a;
        b_out   <= sh_b;
        sum_out <= data_in;
      end
    end
  end

`ifdef SUM_FRAME_RX_ERRCNT_EN
  logic [7:0] cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) cnt <= '0;
    else if (((accept & sum_bad) | ferr) && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end

  assign err_count = cnt;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_sum_frame_receiver.sv
// Directed table-driven bench for sum_frame_receiver plus hand sequences for gaps, reset and saturation.
module tb_sum_frame_receiver;
  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  slot_in = 2'd0;
  logic [15:0] data_in = 16'h0;
  logic [7:0]  a_out, b_out, err_count;
  logic [15:0] sum_out;
  logic        frame_valid, sum_err, frame_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_cnt = 8'h00;

  sum_frame_receiver #(.DATA_W(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .valid_in(valid_in), .slot_in(slot_in),
    .data_in(data_in), .a_out(a_out), .b_out(b_out), .sum_out(sum_out),
    .frame_valid(frame_valid), .sum_err(sum_err), .frame_err(frame_err),
    .err_count(err_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        v;
    logic [1:0]  slot;
    logic [15:0] data;
    logic [2:0]  flags;   // {frame_valid, sum_err, frame_err}
    logic [7:0]  a, b;
    logic [15:0] s;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic v, input logic [1:0] slot, input logic [15:0] data,
                     input logic [2:0] flags, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] s);
    vec_t t;
    t.v = v; t.slot = slot; t.data = data; t.flags = flags; t.a = a; t.b = b; t.s = s;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] slot, input logic [15:0] data);
    @(negedge Clock);
    valid_in = v; slot_in = slot; data_in = data;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] bump(input logic [7:0] c, input logic e);
    bump = (e && c != 8'hFF) ? c + 8'd1 : c;
  endfunction

  function automatic logic [7:0] exp_ec(input logic [7:0] c);
`ifdef SUM_FRAME_RX_ERRCNT_EN
    exp_ec = c;
`else
    exp_ec = 8'h00;
`endif
  endfunction

  initial begin
    // Pre-lock hunting: nonzero slot-0 word and stray operand are ignored.
    add(1, 0, 16'h0012, 3'b000, 8'h00, 8'h00, 16'h0000);
    add(1, 1, 16'h0034, 3'b000, 8'h00, 8'h00, 16'h0000);
    // Good frame.
    add(1, 0, 16'h0000, 3'b000, 8'h00, 8'h00, 16'h0000);
    add(1, 1, 16'h0034, 3'b000, 8'h00, 8'h00, 16'h0000);
    add(1, 2, 16'h0056, 3'b000, 8'h00, 8'h00, 16'h0000);
    add(1, 3, 16'h008A, 3'b100, 8'h34, 8'h56, 16'h008A);
    // Bad sum, back to back.
    add(1, 0, 16'h0000, 3'b000, 8'h34, 8'h56, 16'h008A);
    add(1, 1, 16'h0034, 3'b000, 8'h34, 8'h56, 16'h008A);
    add(1, 2, 16'h0056, 3'b000, 8'h34, 8'h56, 16'h008A);
    add(1, 3, 16'h008B, 3'b110, 8'h34, 8'h56, 16'h008B);
    // Slot 3 where slot 2 expected -> frame_err, then IDLE.
    add(1, 0, 16'h0000, 3'b000, 8'h34, 8'h56, 16'h008B);
    add(1, 1, 16'h00FF, 3'b000, 8'h34, 8'h56, 16'h008B);
    add(1, 3, 16'h01FE, 3'b001, 8'h34, 8'h56, 16'h008B);
    add(1, 2, 16'h0005, 3'b000, 8'h34, 8'h56, 16'h008B);
    add(1, 0, 16'h0000, 3'b000, 8'h34, 8'h56, 16'h008B);
    add(1, 1, 16'h0001, 3'b000, 8'h34, 8'h56, 16'h008B);
    add(1, 2, 16'h0002, 3'b000, 8'h34, 8'h56, 16'h008B);
    add(1, 3, 16'h0003, 3'b100, 8'h01, 8'h02, 16'h0003);
    // Nonzero upper half in A -> frame_err; then FF+FF boundary.
    add(1, 0, 16'h0000, 3'b000, 8'h01, 8'h02, 16'h0003);
    add(1, 1, 16'h0100, 3'b001, 8'h01, 8'h02, 16'h0003);
    add(1, 3, 16'h0000, 3'b000, 8'h01, 8'h02, 16'h0003);
    add(1, 0, 16'h0000, 3'b000, 8'h01, 8'h02, 16'h0003);
    add(1, 1, 16'h00FF, 3'b000, 8'h01, 8'h02, 16'h0003);
    add(1, 2, 16'h00FF, 3'b000, 8'h01, 8'h02, 16'h0003);
    add(1, 3, 16'h01FE, 3'b100, 8'hFF, 8'hFF, 16'h01FE);
    // Stray high bit in sum word -> sum_err.
    add(1, 0, 16'h0000, 3'b000, 8'hFF, 8'hFF, 16'h01FE);
    add(1, 1, 16'h0001, 3'b000, 8'hFF, 8'hFF, 16'h01FE);
    add(1, 2, 16'h0001, 3'b000, 8'hFF, 8'hFF, 16'h01FE);
    add(1, 3, 16'h8002, 3'b110, 8'h01, 8'h01, 16'h8002);
    // Clean sync mid-frame -> frame_err and relock into SYNCED.
    add(1, 0, 16'h0000, 3'b000, 8'h01, 8'h01, 16'h8002);
    add(1, 1, 16'h0007, 3'b000, 8'h01, 8'h01, 16'h8002);
    add(1, 0, 16'h0000, 3'b001, 8'h01, 8'h01, 16'h8002);
    add(1, 1, 16'h0008, 3'b000, 8'h01, 8'h01, 16'h8002);
    add(0, 2, 16'h0000, 3'b000, 8'h01, 8'h01, 16'h8002);
    add(1, 2, 16'h0009, 3'b000, 8'h01, 8'h01, 16'h8002);
    add(1, 3, 16'h0011, 3'b100, 8'h08, 8'h09, 16'h0011);
    // Repeated sync is fine; nonzero slot 0 in HAVE_A is a violation.
    add(1, 0, 16'h0000, 3'b000, 8'h08, 8'h09, 16'h0011);
    add(1, 0, 16'h0000, 3'b000, 8'h08, 8'h09, 16'h0011);
    add(1, 1, 16'h0002, 3'b000, 8'h08, 8'h09, 16'h0011);
    add(1, 2, 16'h0003, 3'b000, 8'h08, 8'h09, 16'h0011);
    add(1, 3, 16'h0005, 3'b100, 8'h02, 8'h03, 16'h0005);
    add(1, 0, 16'h0000, 3'b000, 8'h02, 8'h03, 16'h0005);
    add(1, 1, 16'h0001, 3'b000, 8'h02, 8'h03, 16'h0005);
    add(1, 0, 16'h0005, 3'b001, 8'h02, 8'h03, 16'h0005);
    add(1, 1, 16'h0001, 3'b000, 8'h02, 8'h03, 16'h0005);

    // Reset state.
    #12;
    chk("reset_outputs", {a_out, b_out, sum_out, frame_valid, sum_err, frame_err, err_count},
        {8'h00, 8'h00, 16'h0000, 3'b000, 8'h00});
    @(negedge Clock);
    Resetn = 1'b1;

    foreach (tv[i]) begin
      cyc(tv[i].v, tv[i].slot, tv[i].data);
      exp_cnt = bump(exp_cnt, tv[i].flags[1] | tv[i].flags[0]);
      chk($sformatf("vec%0d_flags", i), {frame_valid, sum_err, frame_err}, tv[i].flags);
      chk($sformatf("vec%0d_data", i), {a_out, b_out, sum_out}, {tv[i].a, tv[i].b, tv[i].s});
      chk($sformatf("vec%0d_errcnt", i), err_count, exp_ec(exp_cnt));
    end

    // Gaps of valid_in=0 between every word.
    begin
      logic [1:0]  gs [4];
      logic [15:0] gd [4];
      gs = '{2'd0, 2'd1, 2'd2, 2'd3};
      gd = '{16'h0000, 16'h0011, 16'h0022, 16'h0033};
      for (int k = 0; k < 4; k++) begin
        cyc(1'b1, gs[k], gd[k]);
        chk($sformatf("gap_fv%0d", k), frame_valid, (k == 3) ? 1'b1 : 1'b0);
        cyc(1'b0, 2'd3, 16'hFFFF);
        cyc(1'b0, 2'd0, 16'h1234);
        chk($sformatf("gap_idle_fv%0d", k), {frame_valid, frame_err}, 2'b00);
      end
      chk("gap_data", {a_out, b_out, sum_out, sum_err}, {8'h11, 8'h22, 16'h0033, 1'b0});
    end

    // Asynchronous reset after the B word of a partial frame.
    cyc(1'b1, 2'd0, 16'h0000);
    cyc(1'b1, 2'd1, 16'h0040);
    cyc(1'b1, 2'd2, 16'h0041);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_reset", {a_out, b_out, sum_out, frame_valid, sum_err, frame_err, err_count},
        {8'h00, 8'h00, 16'h0000, 3'b000, 8'h00});
    exp_cnt = 8'h00;
    @(negedge Clock);
    Resetn = 1'b1;
    cyc(1'b1, 2'd3, 16'h0081);
    chk("post_reset_no_frame", {frame_valid, frame_err, a_out, sum_out}, {2'b00, 8'h00, 16'h0000});

    // 300 bad-sum frames: counter saturates when built in.
    for (int f = 0; f < 300; f++) begin
      cyc(1'b1, 2'd0, 16'h0000);
      cyc(1'b1, 2'd1, 16'h0001);
      cyc(1'b1, 2'd2, 16'h0001);
      cyc(1'b1, 2'd3, 16'h0003);
      exp_cnt = bump(exp_cnt, 1'b1);
      if (f == 0) chk("sat_first_errcnt", err_count, exp_ec(exp_cnt));
    end
    chk("sat_last_flags", {frame_valid, sum_err, frame_err}, 3'b110);
    chk("sat_errcnt", err_count, exp_ec(8'hFF));
    cyc(1'b0, 2'd0, 16'h0000);
    chk("sat_hold", {frame_valid, sum_err, err_count}, {2'b00, exp_ec(8'hFF)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end
endmodule
